// File: rtl/regfile_scoreboard_32x64.sv
// regfile_scoreboard_32x64: 32 x 64-bit register storage plus pending-write
// scoreboard that raises stall for decode on a not-yet-written source.
// Ports: clk, reset (async, active-low), wr_en/wr_addr/wr_data writeback,
//   issue_en/issue_dest from decode, src_a/src_b decode sources;
//   reg_values (packed bus to read muxes), busy flags, pending_cnt, stall.
// Option: define REGFILE_WRITE_THROUGH_EN to forward writeback data onto
//   reg_values and release stall in the writeback cycle itself.
module regfile_scoreboard_32x64 #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [ADDR_W-1:0]                 wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    input  logic                              issue_en,
    input  logic [ADDR_W-1:0]                 issue_dest,
    input  logic [ADDR_W-1:0]                 src_a,
    input  logic [ADDR_W-1:0]                 src_b,
    output logic [NUM_REGS-1:0][DATA_W-1:0]   reg_values,
    output logic [NUM_REGS-1:0]               busy,
    output logic [5:0]                        pending_cnt,
    output logic                              stall
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic [5:0]                      cnt_q, cnt_d;

    logic hazard_a, hazard_b;
    logic issue_ok, set_new, clr_old;

    always_comb begin
        hazard_a = busy_q[src_a] & (src_a != ZERO_A);
        hazard_b = busy_q[src_b] & (src_b != ZERO_A);
`ifdef REGFILE_WRITE_THROUGH_EN
        // The producer is writing back right now, so the operand is ready.
        if (wr_en && (wr_addr == src_a)) hazard_a = 1'b0;
        if (wr_en && (wr_addr == src_b)) hazard_b = 1'b0;
`endif
        stall = hazard_a | hazard_b;
    end

    always_comb begin
        issue_ok = issue_en & ~stall & (issue_dest != ZERO_A);
        // A set on the same register as the clear wins, so that clear
        // does not count as a decrement.
        set_new  = issue_ok & ~busy_q[issue_dest];
        clr_old  = wr_en & busy_q[wr_addr]
                 & ~(issue_ok & (issue_dest == wr_addr));

        busy_d = busy_q;
        if (wr_en) busy_d[wr_addr] = 1'b0;
        if (issue_ok) busy_d[issue_dest] = 1'b1;
        busy_d[ZERO_REG] = 1'b0;

        cnt_d = cnt_q + 6'(set_new) - 6'(clr_old);

        regs_d = regs_q;
        if (wr_en && (wr_addr != ZERO_A)) regs_d[wr_addr] = wr_data;
        regs_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_values[i] = regs_q[i];
`ifdef REGFILE_WRITE_THROUGH_EN
            if (wr_en && (wr_addr == ADDR_W'(i))) reg_values[i] = wr_data;
`endif
        end
        reg_values[ZERO_REG] = '0;
    end

    assign busy        = busy_q;
    assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard_32x64.sv
// tb_regfile_scoreboard_32x64: directed and random stimulus checked
// against an array/popcount reference model of the register file.
module tb_regfile_scoreboard_32x64;

    logic               clk;
    logic               reset;
    logic               wr_en;
    logic [4:0]         wr_addr;
    logic [63:0]        wr_data;
    logic               issue_en;
    logic [4:0]         issue_dest;
    logic [4:0]         src_a;
    logic [4:0]         src_b;
    logic [31:0][63:0]  reg_values;
    logic [31:0]        busy;
    logic [5:0]         pending_cnt;
    logic               stall;

    regfile_scoreboard_32x64 dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_en    (issue_en),
        .issue_dest  (issue_dest),
        .src_a       (src_a),
        .src_b       (src_b),
        .reg_values  (reg_values),
        .busy        (busy),
        .pending_cnt (pending_cnt),
        .stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [63:0] m_regs [32];
    bit          m_busy [32];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic hazard(input logic [4:0] s, input logic we,
                                    input logic [4:0] wa);
        logic h;
        h = m_busy[s] && (s != 5'd31);
`ifdef REGFILE_WRITE_THROUGH_EN
        if (we && wa == s) h = 1'b0;
`endif
        return h;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic check_state();
        for (int i = 0; i < 32; i++)
            check($sformatf("reg%0d", i), reg_values[i], m_regs[i]);
        check("busy", 64'(busy), 64'(m_busy_vec()));
        check("pending_cnt", 64'(pending_cnt), 64'(m_count()));
    endtask

    // Called just after a rising edge; drives one cycle, checks stall
    // before the next edge and the registered state after it.
    task automatic step(input logic we, input logic [4:0] wa,
                        input logic [63:0] wd, input logic ie,
                        input logic [4:0] id, input logic [4:0] sa,
                        input logic [4:0] sb);
        logic exp_stall;
        wr_en = we; wr_addr = wa; wr_data = wd;
        issue_en = ie; issue_dest = id; src_a = sa; src_b = sb;
        #1;
        exp_stall = hazard(sa, we, wa) | hazard(sb, we, wa);
        check("stall", 64'(stall), 64'(exp_stall));
`ifdef REGFILE_WRITE_THROUGH_EN
        if (we && wa != 5'd31) check("wt_data", reg_values[wa], wd);
`endif
        if (we) m_busy[wa] = 1'b0;
        if (we && wa != 5'd31) m_regs[wa] = wd;
        if (ie && !exp_stall && id != 5'd31) m_busy[id] = 1'b1;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        issue_en = 0; issue_dest = 0; src_a = 5'd31; src_b = 5'd31;
    endtask

    task automatic do_reset();
        idle();
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_state();
        check("rst_stall", 64'(stall), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_clear();
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state();
        reset = 1'b1;
        @(posedge clk);
        #1;

        step(1, 5'd5, 64'hDEAD_BEEF, 0, 0, 5'd31, 5'd31);
        step(0, 0, 0, 1, 5'd7, 5'd31, 5'd31);
        // Mid-cycle reset with src_a on a busy register.
        src_a = 5'd7;
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_state();
        check("rst_stall", 64'(stall), 64'd0);
        idle();
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        step(1, 5'd3, 64'hF, 0, 0, 5'd31, 5'd31);
        check("x3", reg_values[3], 64'hF);
        step(1, 5'd31, '1, 1, 5'd31, 5'd31, 5'd31);
        check("x31", reg_values[31], 64'd0);
        check("busy31", 64'(busy[31]), 64'd0);

        step(0, 0, 0, 1, 5'd4, 5'd31, 5'd31);
        step(0, 0, 0, 0, 0, 5'd4, 5'd31);
        step(1, 5'd4, 64'hA0, 0, 0, 5'd4, 5'd31);
        step(0, 0, 0, 0, 0, 5'd4, 5'd31);
        check("x4", reg_values[4], 64'hA0);

        step(0, 0, 0, 1, 5'd9, 5'd31, 5'd31);
        step(1, 5'd9, 64'h99, 1, 5'd9, 5'd31, 5'd31);
        check("same_busy9", 64'(busy[9]), 64'd1);
        check("same_cnt", 64'(pending_cnt), 64'd1);

        do_reset();
        step(0, 0, 0, 1, 5'd1, 5'd31, 5'd31);
        check("seq1", 64'(pending_cnt), 64'd1);
        step(0, 0, 0, 1, 5'd2, 5'd31, 5'd31);
        check("seq2", 64'(pending_cnt), 64'd2);
        step(0, 0, 0, 1, 5'd3, 5'd31, 5'd31);
        check("seq3", 64'(pending_cnt), 64'd3);
        step(1, 5'd2, 64'h22, 1, 5'd10, 5'd31, 5'd31);
        check("seq4", 64'(pending_cnt), 64'd3);
        check("seq_busy", 64'(busy), 64'h40A);

        do_reset();
        step(0, 0, 0, 1, 5'd2, 5'd31, 5'd31);
        step(0, 0, 0, 1, 5'd6, 5'd31, 5'd2);
        check("busy6", 64'(busy[6]), 64'd0);
        for (int i = 0; i < 31; i++)
            step(0, 0, 0, 1, 5'(i), 5'd31, 5'd31);
        check("all_cnt", 64'(pending_cnt), 64'd31);
        step(0, 0, 0, 0, 0, 5'd31, 5'd31);

        do_reset();
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
